// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle for sync_fifo_flags.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_flags_if #(
  parameter int FIFO_WIDTH = 3,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  err_clr;
  logic                  rd_vld;
  logic [FIFO_WIDTH-1:0] rd_data;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [CNT_W-1:0]      fifo_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_vld, rd_data, fifo_empty, fifo_full, almost_empty,
           almost_full, fifo_count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_vld, rd_data, fifo_empty, fifo_full, almost_empty,
           almost_full, fifo_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered latency-1 read.
module sync_fifo_flags #(
  parameter int FIFO_WIDTH    = 3,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_flags_if.slave  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AEMPTY_THRESH);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;

  // A full FIFO still takes a write when a read frees the slot on the same edge.
  assign w_rd_acc = bus.rd_en & (r_count != '0);
  assign w_wr_acc = bus.wr_en & ((r_count != FULL_CNT) | w_rd_acc);

  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en & ~w_wr_acc) r_overflow <= 1'b1;
      else if (bus.err_clr)      r_overflow <= 1'b0;
      if (bus.rd_en & ~w_rd_acc) r_underflow <= 1'b1;
      else if (bus.err_clr)      r_underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.rd_vld  = (r_count != '0);
  assign bus.rd_data = r_mem[r_rd_ptr];
`else
  logic                  r_rd_vld;
  logic [FIFO_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  assign bus.rd_vld  = r_rd_vld;
  assign bus.rd_data = r_rd_data;
`endif

  assign bus.fifo_count   = r_count;
  assign bus.fifo_empty   = (r_count == '0);
  assign bus.fifo_full    = (r_count == FULL_CNT);
  assign bus.almost_empty = (r_count <= AE_CNT);
  assign bus.almost_full  = (r_count >= AF_CNT);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: an 8-deep and a 5-deep instance share stimulus
// and are compared every cycle against queue-based reference models.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.FIFO_WIDTH(3), .FIFO_DEPTH(8)) bus8 ();
  sync_fifo_flags_if #(.FIFO_WIDTH(3), .FIFO_DEPTH(5)) bus5 ();

  sync_fifo_flags #(.FIFO_WIDTH(3), .FIFO_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2))
    dut8 (.clk(clk), .rst(rst), .bus(bus8));
  sync_fifo_flags #(.FIFO_WIDTH(3), .FIFO_DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1))
    dut5 (.clk(clk), .rst(rst), .bus(bus5));

  int checks = 0;
  int failures = 0;

  // Observed vector: {rd_vld, rd_data, empty, full, almost_empty, almost_full, count[3:0], ovf, unf}
  logic [13:0] obs8, obs5, exp8, exp5;
`ifdef FIFO_FWFT_EN
  assign obs8 = {bus8.rd_vld, bus8.rd_data & {3{bus8.rd_vld}}, bus8.fifo_empty, bus8.fifo_full,
                 bus8.almost_empty, bus8.almost_full, bus8.fifo_count, bus8.overflow, bus8.underflow};
  assign obs5 = {bus5.rd_vld, bus5.rd_data & {3{bus5.rd_vld}}, bus5.fifo_empty, bus5.fifo_full,
                 bus5.almost_empty, bus5.almost_full, 1'b0, bus5.fifo_count, bus5.overflow, bus5.underflow};
`else
  assign obs8 = {bus8.rd_vld, bus8.rd_data, bus8.fifo_empty, bus8.fifo_full,
                 bus8.almost_empty, bus8.almost_full, bus8.fifo_count, bus8.overflow, bus8.underflow};
  assign obs5 = {bus5.rd_vld, bus5.rd_data, bus5.fifo_empty, bus5.fifo_full,
                 bus5.almost_empty, bus5.almost_full, 1'b0, bus5.fifo_count, bus5.overflow, bus5.underflow};
`endif

  // Reference model: contents as queues, outputs derived from occupancy.
  logic [2:0] q8 [$];
  logic [2:0] q5 [$];
  logic       vld8, vld5, ov8, ov5, un8, un5;
  logic [2:0] dat8, dat5;

  function automatic logic [13:0] packExp(input int cnt, input int depth, input int afT,
                                          input int aeT, input logic vld, input logic [2:0] d,
                                          input logic ov, input logic un);
    logic [3:0] c;
    c = 4'(cnt);
    return {vld, d, (cnt == 0), (cnt == depth), (cnt <= aeT), (cnt >= afT), c, ov, un};
  endfunction

  task automatic refreshExp();
`ifdef FIFO_FWFT_EN
    exp8 = packExp(q8.size(), 8, 6, 2, q8.size() != 0, (q8.size() != 0) ? q8[0] : 3'd0, ov8, un8);
    exp5 = packExp(q5.size(), 5, 4, 1, q5.size() != 0, (q5.size() != 0) ? q5[0] : 3'd0, ov5, un5);
`else
    exp8 = packExp(q8.size(), 8, 6, 2, vld8, dat8, ov8, un8);
    exp5 = packExp(q5.size(), 5, 4, 1, vld5, dat5, ov5, un5);
`endif
  endtask

  task automatic modelReset();
    q8.delete();
    q5.delete();
    {vld8, vld5, ov8, ov5, un8, un5} = '0;
    dat8 = '0;
    dat5 = '0;
    refreshExp();
  endtask

  task automatic stepModel(input logic wr, input logic [2:0] d, input logic rd, input logic clr);
    logic rdAcc, wrAcc;
    rdAcc = rd && (q8.size() != 0);
    wrAcc = wr && ((q8.size() != 8) || rdAcc);
    if (rdAcc) dat8 = q8.pop_front();
    vld8 = rdAcc;
    if (wrAcc) q8.push_back(d);
    ov8 = (wr && !wrAcc) ? 1'b1 : (clr ? 1'b0 : ov8);
    un8 = (rd && !rdAcc) ? 1'b1 : (clr ? 1'b0 : un8);

    rdAcc = rd && (q5.size() != 0);
    wrAcc = wr && ((q5.size() != 5) || rdAcc);
    if (rdAcc) dat5 = q5.pop_front();
    vld5 = rdAcc;
    if (wrAcc) q5.push_back(d);
    ov5 = (wr && !wrAcc) ? 1'b1 : (clr ? 1'b0 : ov5);
    un5 = (rd && !rdAcc) ? 1'b1 : (clr ? 1'b0 : un5);
    refreshExp();
  endtask

  task automatic driveIn(input logic wr, input logic [2:0] d, input logic rd, input logic clr);
    bus8.wr_en = wr; bus8.wr_data = d; bus8.rd_en = rd; bus8.err_clr = clr;
    bus5.wr_en = wr; bus5.wr_data = d; bus5.rd_en = rd; bus5.err_clr = clr;
  endtask

  // One clock: inputs applied at negedge, model advanced at posedge, outputs settle by +1.
  task automatic tick(input logic wr, input logic [2:0] d, input logic rd, input logic clr);
    @(negedge clk);
    driveIn(wr, d, rd, clr);
    @(posedge clk);
    stepModel(wr, d, rd, clr);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    driveIn(1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    modelReset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    driveIn(1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if (obs8 !== exp8) begin failures++; $display("[TB] FAIL reset_dut8 got=%h exp=%h", obs8, exp8); end
    checks++;
    if (obs5 !== exp5) begin failures++; $display("[TB] FAIL reset_dut5 got=%h exp=%h", obs5, exp5); end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b0);
      checks++;
      if (obs8 !== exp8) begin failures++; $display("[TB] FAIL idle_dut8 c=%0d got=%h exp=%h", i, obs8, exp8); end
      checks++;
      if (bus8.fifo_empty !== 1'b1 || bus8.almost_empty !== 1'b1 || bus8.fifo_count !== 4'd0) begin
        failures++;
        $display("[TB] FAIL idle_flags empty=%b aempty=%b count=%0d exp 1 1 0",
                 bus8.fifo_empty, bus8.almost_empty, bus8.fifo_count);
      end
    end
  endtask

  task automatic test_fill_drain();
    applyReset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 3'(i), 1'b0, 1'b0);
      checks++;
      if (obs8 !== exp8) begin failures++; $display("[TB] FAIL fill_dut8 i=%0d got=%h exp=%h", i, obs8, exp8); end
      checks++;
      if (obs5 !== exp5) begin failures++; $display("[TB] FAIL fill_dut5 i=%0d got=%h exp=%h", i, obs5, exp5); end
    end
    checks++;
    if (bus8.fifo_count !== 4'd8 || bus8.fifo_full !== 1'b1 || bus8.almost_full !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_flags count=%0d full=%b afull=%b exp 8 1 1",
               bus8.fifo_count, bus8.fifo_full, bus8.almost_full);
    end
    tick(1'b1, 3'd5, 1'b0, 1'b0);
    checks++;
    if (bus8.overflow !== 1'b1 || bus8.fifo_count !== 4'd8) begin
      failures++;
      $display("[TB] FAIL overflow_set ovf=%b count=%0d exp 1 8", bus8.overflow, bus8.fifo_count);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 3'd0, 1'b1, 1'b0);
      checks++;
      if (obs8 !== exp8) begin failures++; $display("[TB] FAIL drain_dut8 i=%0d got=%h exp=%h", i, obs8, exp8); end
      checks++;
      if (obs5 !== exp5) begin failures++; $display("[TB] FAIL drain_dut5 i=%0d got=%h exp=%h", i, obs5, exp5); end
    end
  endtask

  task automatic test_wrap();
    applyReset();
    for (int i = 0; i < 8; i++) tick(1'b1, 3'(7 - i), 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    checks++;
    if (obs5 !== exp5) begin failures++; $display("[TB] FAIL wrap_clr_dut5 got=%h exp=%h", obs5, exp5); end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 3'(i), 1'b1, 1'b0);
      checks++;
      if (obs8 !== exp8) begin failures++; $display("[TB] FAIL wrap_dut8 i=%0d got=%h exp=%h", i, obs8, exp8); end
      checks++;
      if (obs5 !== exp5) begin failures++; $display("[TB] FAIL wrap_dut5 i=%0d got=%h exp=%h", i, obs5, exp5); end
    end
    checks++;
    if (bus8.overflow !== 1'b0 || bus8.fifo_count !== 4'd8 || bus5.fifo_count !== 3'd5) begin
      failures++;
      $display("[TB] FAIL wrap_steady ovf=%b count8=%0d count5=%0d exp 0 8 5",
               bus8.overflow, bus8.fifo_count, bus5.fifo_count);
    end
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 3'd0, 1'b1, 1'b0);
      checks++;
      if (obs8 !== exp8) begin failures++; $display("[TB] FAIL wrapdrain_dut8 i=%0d got=%h exp=%h", i, obs8, exp8); end
      checks++;
      if (obs5 !== exp5) begin failures++; $display("[TB] FAIL wrapdrain_dut5 i=%0d got=%h exp=%h", i, obs5, exp5); end
    end
  endtask

  task automatic test_underflow();
    applyReset();
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    checks++;
    if (bus8.underflow !== 1'b1 || bus8.rd_vld !== 1'b0) begin
      failures++;
      $display("[TB] FAIL underflow_set unf=%b vld=%b exp 1 0", bus8.underflow, bus8.rd_vld);
    end
    tick(1'b1, 3'd3, 1'b1, 1'b0);
    checks++;
    if (obs8 !== exp8) begin failures++; $display("[TB] FAIL empty_rdwr_dut8 got=%h exp=%h", obs8, exp8); end
    checks++;
    if (bus8.fifo_count !== 4'd1) begin
      failures++;
      $display("[TB] FAIL empty_rdwr_count got=%0d exp=1", bus8.fifo_count);
    end
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    checks++;
    if (bus8.underflow !== 1'b0) begin failures++; $display("[TB] FAIL err_clr unf=%b exp=0", bus8.underflow); end
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    checks++;
    if (obs8 !== exp8) begin failures++; $display("[TB] FAIL pop3_dut8 got=%h exp=%h", obs8, exp8); end
    tick(1'b0, 3'd0, 1'b1, 1'b1);
    checks++;
    if (obs8 !== exp8) begin failures++; $display("[TB] FAIL set_beats_clr_dut8 got=%h exp=%h", obs8, exp8); end
    checks++;
    if (obs5 !== exp5) begin failures++; $display("[TB] FAIL set_beats_clr_dut5 got=%h exp=%h", obs5, exp5); end
  endtask

  task automatic test_reset_mid();
    applyReset();
    for (int i = 0; i < 4; i++) tick(1'b1, 3'(i + 1), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if (obs8 !== exp8) begin failures++; $display("[TB] FAIL midreset_dut8 got=%h exp=%h", obs8, exp8); end
    checks++;
    if (obs5 !== exp5) begin failures++; $display("[TB] FAIL midreset_dut5 got=%h exp=%h", obs5, exp5); end
    rst = 1'b0;
    tick(1'b1, 3'd6, 1'b0, 1'b0);
    checks++;
    if (obs8 !== exp8) begin failures++; $display("[TB] FAIL postreset_wr_dut8 got=%h exp=%h", obs8, exp8); end
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    checks++;
    if (obs8 !== exp8) begin failures++; $display("[TB] FAIL postreset_rd_dut8 got=%h exp=%h", obs8, exp8); end
`ifndef FIFO_FWFT_EN
    checks++;
    if (bus8.rd_data !== 3'd6 || bus8.rd_vld !== 1'b1) begin
      failures++;
      $display("[TB] FAIL postreset_data data=%0d vld=%b exp 6 1", bus8.rd_data, bus8.rd_vld);
    end
`endif
  endtask

  task automatic test_random();
    logic wr, rd, clr;
    applyReset();
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
      rd  = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
      clr = ($urandom_range(0, 99) < 8);
      tick(wr, 3'($urandom_range(0, 7)), rd, clr);
      checks++;
      if (obs8 !== exp8) begin failures++; $display("[TB] FAIL random_dut8 i=%0d got=%h exp=%h", i, obs8, exp8); end
      checks++;
      if (obs5 !== exp5) begin failures++; $display("[TB] FAIL random_dut5 i=%0d got=%h exp=%h", i, obs5, exp5); end
    end
  endtask

  initial begin
    driveIn(1'b0, 3'd0, 1'b0, 1'b0);
    modelReset();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8x3 FIFO.
- Generalised in width and depth (any depth ≥ 2, not only powers of two).
- Adds occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Sits between producer/consumer blocks in the datapath; drop-in for the old FIFO's port set plus the new outputs.

Parameters:
- FIFO_WIDTH, 3, data word width in bits (≥ 1).
- FIFO_DEPTH, 8, number of entries (≥ 2).
- AFULL_THRESH, 6, almost_full asserts when count ≥ this value (1..FIFO_DEPTH).
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this value (0..FIFO_DEPTH-1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  FIFO_WIDTH  write data.
- rd_en  in  1  read request.
- rd_vld  out  1  rd_data valid (one-cycle pulse per accepted read).
- rd_data  out  FIFO_WIDTH  read data.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == FIFO_DEPTH.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.
- almost_full  out  1  count ≥ AFULL_THRESH.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- err_clr  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async assert, any cycle incl. mid-transfer):
  - wr_ptr, rd_ptr, count = 0; storage contents discarded (RAM need not be cleared).
  - rd_vld = 0, rd_data = 0, overflow = underflow = 0.
  - Flags: fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = 0.
- Acceptance, evaluated on the rising edge:
  - rd_acc = rd_en & (count != 0).
  - wr_acc = wr_en & (count != FIFO_DEPTH | rd_acc).
  - Full with simultaneous read and write: both accepted; count unchanged.
  - Empty with simultaneous read and write: write accepted, read rejected (no bypass); count 0→1.
- Write: mem[wr_ptr] ← wr_data; wr_ptr wraps FIFO_DEPTH-1 → 0.
- Read: rd_data ← mem[rd_ptr] and rd_vld = 1 on the edge after rd_en is sampled (latency 1); rd_ptr wraps the same way.
  - No accepted read: rd_vld = 0 and rd_data holds its last value.
- Count: +1 on write only, −1 on read only, unchanged on both or neither.
- Flags and fifo_count are decoded from the registered count; they update on the same edge that commits the operation.
- Error flags:
  - overflow set when wr_en & !wr_acc.
  - underflow set when rd_en & !rd_acc.
  - Both sticky until err_clr or rst. A set event in the same cycle as err_clr wins (flag stays 1).
- Rejected operations have no side effects on pointers or storage.
- Ordering: strict FIFO; data out equals data in, in order, across pointer wrap.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data continuously shows mem[rd_ptr]; rd_vld = !fifo_empty (combinational from count).
  - rd_en pops the head on the edge; read latency 0.
  - Acceptance, count and error rules unchanged.
- Undefined: registered latency-1 read as described above.

Test Plan:
- Reset then idle: fifo_empty = 1, almost_empty = 1, fifo_count = 0, rd_vld = 0, overflow = underflow = 0.
- Write 0..7 on consecutive cycles: fifo_count reaches 8, almost_full rises when count = 6, fifo_full at 8. 9th write of 5 → overflow = 1, count stays 8. Then read 8 times → rd_data 0..7, each one cycle after rd_en.
- Fill to 8, then rd_en = wr_en = 1 for 20 cycles with data i: count stays 8, no overflow, output sequence continuous across pointer wrap. Repeat with FIFO_DEPTH = 5.
- Empty FIFO, rd_en = 1 alone → underflow = 1, rd_vld = 0. Then rd_en = wr_en = 1 with data 3 → count = 1, no rd_vld. err_clr → underflow = 0.
- Write 4 entries, assert rst mid-cycle between edges: outputs return to reset values immediately. Write 6 then read → rd_data 6 (old data gone).
- FIFO_FWFT_EN build: write 2 → rd_vld = 1 and rd_data = 2 the cycle after the write, with no rd_en. rd_en pops the entry; empty on the next edge.
